corner_collector: RTL and testbench
===================================

// Module: corner_collector
// PURPOSE
//  Sink for the NMS output stream. Samples {x_coord, y_coord, corner} each ce cycle,
//  buffers surviving corners in a FIFO and drains them downstream as a valid/ready
//  word stream (x,y per corner). Closes each frame with one end-of-frame (EOF) word
//  carrying the frame's corner count and an overflow flag. Sits after NMS, before DMA/host.
// PARAMETERS
//  X_W     10   x coordinate width
//  Y_W     10   y coordinate width
//  DEPTH   64   FIFO depth in words, power of 2, >=4
//  CNT_W   11   per-frame corner counter width (saturating)
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  rst          in   1        asynchronous, active-low reset
//  ce           in   1        pipeline enable, same qualifier as NMS
//  x_coord_in   in   X_W      x of NMS centre pixel
//  y_coord_in   in   Y_W      y of NMS centre pixel
//  corner_in    in   1        NMS corner_out; sampled only when ce=1
//  frame_end    in   1        1-cycle pulse after last pixel of frame left NMS; ce-independent
//  m_valid      out  1        output word valid
//  m_ready      in   1        downstream accept
//  m_data       out  X_W+Y_W+1 output word (layout below)
//  corner_count out  CNT_W    running count of corners accepted in current frame
//  overflow     out  1        sticky: >=1 corner dropped in current frame
//  busy         out  1        FIFO non-empty or EOF pending
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, m_valid=0, m_data=0, corner_count=0, overflow=0,
//   busy=0, FSM=COLLECT. Reset mid-frame discards all buffered words, no EOF emitted.
//  Word layout (W=X_W+Y_W+1): bit W-1 = LAST tag.
//   LAST=0: [W-2:Y_W]=x, [Y_W-1:0]=y.  LAST=1: [W-2]=overflow, [CNT_W-1:0]=count, rest 0.
//  Corner accept: ce&corner_in in COLLECT and free slots >=2 -> push {0,x,y},
//   corner_count+=1 (saturates at 2^CNT_W-1). One slot always reserved for EOF.
//  Drop: ce&corner_in with free slots <2, or in EOF_WAIT -> no push, overflow<=1
//   (in EOF_WAIT the drop belongs to the next frame: flag applied after EOF written).
//  FSM COLLECT: frame_end & free>=1 -> push EOF{overflow',count'} same cycle, clear
//   count/overflow next cycle, stay COLLECT. frame_end & FIFO full -> EOF_WAIT.
//   count'/overflow' include a corner accepted in the same cycle as frame_end.
//  FSM EOF_WAIT: holds latched count/flag; on first cycle with free>=1 push EOF,
//   clear counters, -> COLLECT. frame_end in EOF_WAIT is ignored (protocol error).
//  Same-cycle push and pop allowed at any level, including full (pop frees slot for push
//   only in the next cycle: free-slot test uses registered occupancy).
//  Output: first-word fall-through; m_valid=!empty; pop when m_valid&m_ready.
//   m_data stable while m_valid&!m_ready. Latency input sample -> m_valid = 1 cycle.
//  Pointers: log2(DEPTH)+1 bits, wrap naturally; full/empty from MSB compare.
//  corner_count/overflow are registered, visible the cycle after the event.
// STRUCTURE
//  nms_defs.vh (shared): X_W/Y_W defaults, LAST bit index, EOF field offsets,
//   FSM state encodings COLLECT=1'b0, EOF_WAIT=1'b1.
//  Sub-module corner_fifo: sync FWFT FIFO (DEPTH x W, occupancy output, async active-low rst).
//  Top: accept/drop logic, counters, EOF FSM, output mux.
// TESTING
//  T1 3 corners (1,1),(5,2),(639,479) then frame_end, m_ready=1 -> 4 words:
//     3 coord words in order, EOF {LAST=1,ovf=0,count=3}; busy falls after EOF pop.
//  T2 DEPTH=64, m_ready=0, 70 corners -> 63 accepted, overflow=1, count=63; frame_end ->
//     EOF written into last slot; drain yields 63 coords + EOF{ovf=1,count=63}.
//  T3 FIFO full (64 incl. prior EOF), frame_end -> EOF_WAIT; corner during wait dropped;
//     one pop -> EOF{count} pushed next cycle; next frame EOF shows ovf=1.
//  T4 corner_in and frame_end same cycle, count was 4 -> EOF count=5, next frame count=0.
//  T5 corner_in=1 with ce=0 for 10 cycles -> no push, count unchanged.
//  T6 rst low mid-drain with 10 words queued -> m_valid=0 immediately, all outputs 0;
//     after release new frame of 2 corners + frame_end -> exactly 3 words out.

Source files
------------

// File: rtl/corner_collector_pkg.sv
// Shared defaults and FSM state type for the corner collector.
// Pure definitions: no logic, no latency.
package corner_collector_pkg;

   localparam int X_W_DEF   = 10;
   localparam int Y_W_DEF   = 10;
   localparam int DEPTH_DEF = 64;
   localparam int CNT_W_DEF = 11;

   typedef enum logic {
      COLLECT  = 1'b0,
      EOF_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/corner_collector_fifo.sv
// FWFT FIFO with up to two in-order writes per cycle; write -> rd_vld is 1 cycle.
// Reader backpressure via rd_rdy; writer must check occ/full, writes into a full FIFO are not guarded.
module corner_collector_fifo #(
   parameter int W     = 21,
   parameter int DEPTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr0_vld,
   input  logic [W-1:0]              wr0_dat,
   input  logic                      wr1_vld,
   input  logic [W-1:0]              wr1_dat,
   input  logic                      rd_rdy,
   output logic                      rd_vld,
   output logic [W-1:0]              rd_dat,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    occ
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp_q;
   logic [AW:0]  rp_q;
   logic [AW:0]  wp1;
   logic         empty;
   logic         pop;

   assign empty  = (wp_q == rp_q);
   assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign occ    = wp_q - rp_q;
   assign rd_vld = !empty;
   assign rd_dat = empty ? '0 : mem[rp_q[AW-1:0]];
   assign pop    = rd_vld & rd_rdy;
   // second write lands behind the first when both are present
   assign wp1    = wr0_vld ? wp_q + (AW+1)'(1) : wp_q;

   always_ff @(posedge clk) begin
      if (wr0_vld) mem[wp_q[AW-1:0]] <= wr0_dat;
      if (wr1_vld) mem[wp1[AW-1:0]]  <= wr1_dat;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_q + (AW+1)'(wr0_vld) + (AW+1)'(wr1_vld);
         if (pop) rp_q <= rp_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/corner_collector.sv
// Collects NMS corners into a FIFO and emits coord words plus one EOF word per frame; sample -> m_valid 1 cycle.
// Downstream stalls via m_ready; when the FIFO fills, corners are dropped (flagged) and EOF waits for a slot.
module corner_collector
   import corner_collector_pkg::*;
#(
   parameter int X_W   = X_W_DEF,
   parameter int Y_W   = Y_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic [X_W-1:0]         x_coord_in,
   input  logic [Y_W-1:0]         y_coord_in,
   input  logic                   corner_in,
   input  logic                   frame_end,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [X_W+Y_W:0]       m_data,
   output logic [CNT_W-1:0]       corner_count,
   output logic                   overflow,
   output logic                   busy
);

   localparam int W  = X_W + Y_W + 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
   logic             ovf_q, ovf_d, ovf_nxt;
   logic             ovf_pend_q, ovf_pend_d;
   logic [AW:0]      occ;
   logic [AW:0]      free;
   logic             fifo_full;
   logic             smp;
   logic             accept_vld;
   logic             drop;
   logic             eof_vld;
   logic [W-1:0]     coord_dat;
   logic [W-1:0]     eof_dat;

   assign smp       = ce & corner_in;
   assign free      = (AW+1)'(DEPTH) - occ;
   assign coord_dat = {1'b0, x_coord_in, y_coord_in};

   always_comb begin
      state_d    = state_q;
      cnt_nxt    = cnt_q;
      ovf_nxt    = ovf_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      ovf_pend_d = ovf_pend_q;
      accept_vld = 1'b0;
      drop       = 1'b0;
      eof_vld    = 1'b0;
      unique case (state_q)
         COLLECT: begin
            // one slot is always held back so the EOF word can follow
            accept_vld = smp && (free >= (AW+1)'(2));
            drop       = smp && !accept_vld;
            if (accept_vld && (cnt_q != CNT_MAX)) cnt_nxt = cnt_q + CNT_W'(1);
            ovf_nxt = ovf_q | drop;
            cnt_d   = cnt_nxt;
            ovf_d   = ovf_nxt;
            if (frame_end) begin
               if (!fifo_full) begin
                  eof_vld = 1'b1;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = EOF_WAIT;
               end
            end
         end
         EOF_WAIT: begin
            // drops here are charged to the frame that follows the pending EOF
            drop       = smp;
            ovf_pend_d = ovf_pend_q | drop;
            if (!fifo_full) begin
               eof_vld    = 1'b1;
               cnt_d      = '0;
               ovf_d      = ovf_pend_d;
               ovf_pend_d = 1'b0;
               state_d    = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      eof_dat              = '0;
      eof_dat[W-1]         = 1'b1;
      eof_dat[W-2]         = ovf_nxt;
      eof_dat[CNT_W-1:0]   = cnt_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= COLLECT;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         ovf_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         ovf_pend_q <= ovf_pend_d;
      end
   end

   corner_collector_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr0_vld (accept_vld),
      .wr0_dat (coord_dat),
      .wr1_vld (eof_vld),
      .wr1_dat (eof_dat),
      .rd_rdy  (m_ready),
      .rd_vld  (m_valid),
      .rd_dat  (m_data),
      .full    (fifo_full),
      .occ     (occ)
   );

   assign corner_count = cnt_q;
   assign overflow     = ovf_q;
   assign busy         = m_valid | (state_q == EOF_WAIT);

endmodule

// File: tb/tb_corner_collector.sv
// Bench for corner_collector: directed table, corner-case sequences and random traffic vs a queue model.
module tb_corner_collector;

   localparam int DEPTH   = 64;
   localparam int CNT_MAX = 2047;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [9:0]  x_coord_in;
   logic [9:0]  y_coord_in;
   logic        corner_in;
   logic        frame_end;
   logic        m_valid;
   logic        m_ready;
   logic [20:0] m_data;
   logic [10:0] corner_count;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   corner_collector dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .x_coord_in   (x_coord_in),
      .y_coord_in   (y_coord_in),
      .corner_in    (corner_in),
      .frame_end    (frame_end),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .corner_count (corner_count),
      .overflow     (overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] cw(input logic [9:0] x, input logic [9:0] y);
      return {1'b0, x, y};
   endfunction

   function automatic logic [20:0] ew(input bit o, input logic [10:0] c);
      return {1'b1, o, 8'h00, c};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // reference model: FIFO contents as a queue, frame bookkeeping as plain variables
   logic [20:0] mq[$];
   logic [20:0] popped[$];
   int          m_cnt;
   bit          m_ovf, m_wait, m_pend;

   task automatic model_reset();
      mq.delete();
      m_cnt  = 0;
      m_ovf  = 0;
      m_wait = 0;
      m_pend = 0;
   endtask

   task automatic model_step(input bit c, input bit cor, input logic [9:0] x, input logic [9:0] y,
                             input bit fe, input bit rdy);
      int          free = DEPTH - mq.size();
      bit          pop  = (mq.size() > 0) && rdy;
      bit          hit  = c && cor;
      logic [20:0] push[$];
      if (!m_wait) begin
         if (hit && free >= 2) begin
            push.push_back(cw(x, y));
            if (m_cnt < CNT_MAX) m_cnt++;
         end else if (hit) begin
            m_ovf = 1;
         end
         if (fe) begin
            if (free >= 1) begin
               push.push_back(ew(m_ovf, 11'(m_cnt)));
               m_cnt = 0;
               m_ovf = 0;
            end else begin
               m_wait = 1;
            end
         end
      end else begin
         if (hit) m_pend = 1;
         if (free >= 1) begin
            push.push_back(ew(m_ovf, 11'(m_cnt)));
            m_cnt  = 0;
            m_ovf  = m_pend;
            m_pend = 0;
            m_wait = 0;
         end
      end
      if (pop) void'(mq.pop_front());
      foreach (push[i]) mq.push_back(push[i]);
   endtask

   task automatic cycle(input bit c, input bit cor, input logic [9:0] x, input logic [9:0] y,
                        input bit fe, input bit rdy);
      ce         = c;
      corner_in  = cor;
      x_coord_in = x;
      y_coord_in = y;
      frame_end  = fe;
      m_ready    = rdy;
      if (m_valid && rdy) popped.push_back(m_data);
      @(posedge clk);
      model_step(c, cor, x, y, fe, rdy);
      #1;
      chk("m_valid", 32'(m_valid), 32'(mq.size() > 0));
      chk("m_data", 32'(m_data), 32'(mq.size() > 0 ? mq[0] : 21'h0));
      chk("corner_count", 32'(corner_count), 32'(m_cnt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("busy", 32'(busy), 32'((mq.size() > 0) || m_wait));
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, 32'(m_valid), 32'h0);
      chk({tag, "_data"}, 32'(m_data), 32'h0);
      chk({tag, "_count"}, 32'(corner_count), 32'h0);
      chk({tag, "_ovf"}, 32'(overflow), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   typedef struct {
      bit          c, cor;
      logic [9:0]  x, y;
      bit          fe, rdy;
      bit          v;
      logic [20:0] d;
      logic [10:0] cnt;
      bit          ovf, bsy;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit c, input bit cor, input logic [9:0] x, input logic [9:0] y,
                      input bit fe, input bit rdy, input bit v, input logic [20:0] d,
                      input logic [10:0] cnt, input bit ovf, input bit bsy);
      vec_t r;
      r.c = c; r.cor = cor; r.x = x; r.y = y; r.fe = fe; r.rdy = rdy;
      r.v = v; r.d = d; r.cnt = cnt; r.ovf = ovf; r.bsy = bsy;
      vecs.push_back(r);
   endtask

   function automatic logic [20:0] pick(input int i);
      return (i < popped.size()) ? popped[i] : 21'h0;
   endfunction

   initial begin
      // three coordinate words then EOF, full-rate drain
      add(1, 1,   1,   1, 0, 1, 1, cw(1, 1),     1, 0, 1);
      add(1, 1,   5,   2, 0, 1, 1, cw(5, 2),     2, 0, 1);
      add(1, 1, 639, 479, 0, 1, 1, cw(639, 479), 3, 0, 1);
      add(0, 0,   0,   0, 1, 1, 1, ew(0, 3),     0, 0, 1);
      add(0, 0,   0,   0, 0, 1, 0, 21'h0,        0, 0, 0);
      // corner coinciding with frame_end is counted in that frame's EOF
      for (int i = 0; i < 4; i++)
         add(1, 1, 10'(10 + i), 10'(20 + i), 0, 1, 1, cw(10'(10 + i), 10'(20 + i)), 11'(i + 1), 0, 1);
      add(1, 1, 14, 24, 1, 1, 1, cw(14, 24), 0, 0, 1);
      add(0, 0,  0,  0, 0, 1, 1, ew(0, 5),   0, 0, 1);
      add(0, 0,  0,  0, 0, 1, 0, 21'h0,      0, 0, 0);
      // corner_in without ce is ignored
      for (int i = 0; i < 10; i++)
         add(0, 1, 7, 7, 0, 1, 0, 21'h0, 0, 0, 0);

      rst = 1'b0;
      ce = 0; corner_in = 0; frame_end = 0; m_ready = 0; x_coord_in = 0; y_coord_in = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         cycle(vecs[i].c, vecs[i].cor, vecs[i].x, vecs[i].y, vecs[i].fe, vecs[i].rdy);
         chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(vecs[i].v));
         chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(vecs[i].d));
         chk($sformatf("tbl%0d_count", i), 32'(corner_count), 32'(vecs[i].cnt));
         chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      end

      // fill with downstream stalled: 63 accepted, rest dropped
      for (int i = 0; i < 70; i++) cycle(1, 1, 10'(i), 10'(i + 1), 0, 0);
      chk("fill_count", 32'(corner_count), 32'd63);
      chk("fill_ovf", 32'(overflow), 32'd1);
      cycle(0, 0, 0, 0, 1, 0);
      chk("fill_eof_count_clr", 32'(corner_count), 32'd0);
      chk("fill_eof_ovf_clr", 32'(overflow), 32'd0);
      chk("fill_head", 32'(m_data), 32'(cw(0, 1)));

      // frame_end into a full FIFO parks the EOF
      cycle(0, 0, 0, 0, 1, 0);
      chk("wait_busy", 32'(busy), 32'd1);
      cycle(1, 1, 3, 3, 0, 0);
      chk("wait_ovf_held", 32'(overflow), 32'd0);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      chk("wait_ovf_next", 32'(overflow), 32'd1);
      chk("wait_count_next", 32'(corner_count), 32'd0);
      popped.delete();
      for (int i = 0; i < 70; i++) cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("drain_words", 32'(popped.size()), 32'd65);
      chk("drain_first", 32'(pick(0)), 32'(cw(1, 2)));
      chk("drain_eof_ovf", 32'(pick(62)), 32'(ew(1, 63)));
      chk("drain_eof_wait", 32'(pick(63)), 32'(ew(0, 0)));
      chk("drain_eof_next", 32'(pick(64)), 32'(ew(1, 0)));

      // random traffic under three backpressure levels
      for (int ph = 0; ph < 3; ph++) begin
         for (int i = 0; i < 1000; i++) begin
            cycle($urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1,
                  10'($urandom), 10'($urandom), $urandom_range(0, 49) == 0,
                  $urandom_range(0, 99) < (ph == 0 ? 30 : (ph == 1 ? 70 : 95)));
         end
      end
      for (int i = 0; i < 80; i++) cycle(0, 0, 0, 0, 0, 1);
      chk("rand_settled", 32'(busy), 32'd0);

      // reset mid-drain discards everything
      for (int i = 0; i < 10; i++) cycle(1, 1, 10'(100 + i), 10'(200 + i), 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      #2;
      rst = 1'b0;
      ce = 0; corner_in = 0; frame_end = 0; m_ready = 0;
      #1;
      chk_idle_outputs("arst");
      model_reset();
      @(posedge clk);
      #1;
      chk_idle_outputs("arst_hold");
      rst = 1'b1;
      popped.delete();
      cycle(1, 1, 30, 40, 0, 1);
      cycle(1, 1, 31, 41, 0, 1);
      cycle(0, 0, 0, 0, 1, 1);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1);
      chk("post_rst_words", 32'(popped.size()), 32'd3);
      chk("post_rst_eof", 32'(pick(2)), 32'(ew(0, 2)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
